microcode_pipeline_scheduler: RTL and testbench

Sequencing controller for the four-stage microcode pipeline (S0 operand/compare, S1 ALU, S2 memory/branch, S3 writeback). It accepts decoded microcode words plus register indices from the issue stage, moves them through per-stage registers feeding the S0–S3 field decoders, and detects read-after-write hazards. It stalls or bubbles the pipe on a hazard, flushes younger stages on a taken branch, and arbitrates the single memory port between instruction fetch and data access.

---
 rtl/microcode_pipeline_scheduler_pkg.sv | 41 ++++
 rtl/microcode_pipeline_scheduler_if.sv | 22 ++
 rtl/microcode_pipeline_scheduler_hazard_detect.sv | 47 ++++
 rtl/microcode_pipeline_scheduler.sv | 127 ++++++++++++
 tb/tb_microcode_pipeline_scheduler.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/microcode_pipeline_scheduler_pkg.sv
// Shared types and microcode field positions for the four-stage microcode pipeline scheduler.
package microcode_pkg;

  localparam int MC_W   = 25;
  localparam int RIDX_W = 5;

  localparam int CHECK_RS1_BIT      = 0;
  localparam int CHECK_RS2_BIT      = 1;
  localparam int MEM_IN_USE_BIT     = 10;
  localparam int MEM_WRITE_BIT      = 15;
  localparam int JUMP_IF_BRANCH_BIT = 19;
  localparam int REG_WRITE_BIT      = 22;
  localparam int USE_PRE_WB_BIT     = 23;
  localparam int SEXT_MEM_BIT       = 24;

  typedef enum logic [1:0] {
    FWD_REGFILE   = 2'd0,
    FWD_S2_PRE_WB = 2'd1,
    FWD_S3_WB     = 2'd2
  } fwd_sel_e;

  typedef struct packed {
    logic              valid;
    logic [MC_W-1:0]   mc;
    logic [RIDX_W-1:0] rs1;
    logic [RIDX_W-1:0] rs2;
    logic [RIDX_W-1:0] rd;
  } stage_t;

  // Stages past S0 only ever act as producers, so their source indices are not kept.
  typedef struct packed {
    logic              valid;
    logic [MC_W-1:0]   mc;
    logic [RIDX_W-1:0] rd;
  } prod_t;

  function automatic logic is_load(input logic [MC_W-1:0] mc);
    return mc[REG_WRITE_BIT] & ~mc[USE_PRE_WB_BIT];
  endfunction

endpackage

// File: rtl/microcode_pipeline_scheduler_if.sv
// Issue-stage handshake into the scheduler: valid/ready plus microcode word and register indices.
interface microcode_pipeline_scheduler_if;
  import microcode_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [MC_W-1:0]   in_microcode;
  logic [RIDX_W-1:0] in_rs1;
  logic [RIDX_W-1:0] in_rs2;
  logic [RIDX_W-1:0] in_rd;

  modport master (
    output in_valid, in_microcode, in_rs1, in_rs2, in_rd,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_microcode, in_rs1, in_rs2, in_rd,
    output in_ready
  );

endinterface

// File: rtl/microcode_pipeline_scheduler_hazard_detect.sv
// RAW hazard check of the S0 sources against S1..S3 producers; purely combinational, no backpressure.
// With SCHED_FORWARD_EN the S2/S3 producers are bypassed and forward selects are produced.
module hazard_detect
  import microcode_pkg::*;
(
  input  logic                   [RIDX_W-1:0] rs1,
  input  logic                   [RIDX_W-1:0] rs2,
  input  logic                                chk1,
  input  logic                                chk2,
  input  logic                   [2:0]        prod_wr,
  input  logic [2:0][RIDX_W-1:0]              prod_rd,
`ifdef SCHED_FORWARD_EN
  input  logic                                s2_load,
  output fwd_sel_e                            fwd_a_sel,
  output fwd_sel_e                            fwd_b_sel,
`endif
  output logic                                hazard
);

  logic [2:0] match_a;
  logic [2:0] match_b;

  always_comb begin
    for (int k = 0; k < 3; k++) begin
      match_a[k] = chk1 & (rs1 != '0) & prod_wr[k] & (prod_rd[k] == rs1);
      match_b[k] = chk2 & (rs2 != '0) & prod_wr[k] & (prod_rd[k] == rs2);
    end
  end

`ifdef SCHED_FORWARD_EN
  // Only an S1 producer or a load still in S2 lacks a bypassable result.
  assign hazard = match_a[0] | match_b[0] | (s2_load & (match_a[1] | match_b[1]));

  always_comb begin
    fwd_a_sel = FWD_REGFILE;
    if (match_a[1])      fwd_a_sel = FWD_S2_PRE_WB;
    else if (match_a[2]) fwd_a_sel = FWD_S3_WB;
    fwd_b_sel = FWD_REGFILE;
    if (match_b[1])      fwd_b_sel = FWD_S2_PRE_WB;
    else if (match_b[2]) fwd_b_sel = FWD_S3_WB;
  end
`else
  // Register file is not write-through, so even an S3 producer must retire first.
  assign hazard = (|match_a) | (|match_b);
`endif

endmodule

// File: rtl/microcode_pipeline_scheduler.sv
// Four-stage microcode sequencer: S0 visible 1 cycle after accept, S3 3 cycles later; in_ready drops on hazard stall or branch kill.
// Optional operand forwarding enabled by defining SCHED_FORWARD_EN.
module microcode_pipeline_scheduler
  import microcode_pkg::*;
(
  input  logic                           clk,
  input  logic                           rst_n,
  microcode_pipeline_scheduler_if.slave  issue,
  input  logic                           branch_taken,
  output logic                           s0_valid,
  output logic                           s1_valid,
  output logic                           s2_valid,
  output logic                           s3_valid,
  output logic [MC_W-1:0]                s0_mc,
  output logic [MC_W-1:0]                s1_mc,
  output logic [MC_W-1:0]                s2_mc,
  output logic [MC_W-1:0]                s3_mc,
  output logic [RIDX_W-1:0]              s3_rd,
  output logic                           stall,
  output logic                           fetch_mem_grant,
`ifdef SCHED_FORWARD_EN
  output fwd_sel_e                       fwd_a_sel,
  output fwd_sel_e                       fwd_b_sel,
`endif
  output logic [31:0]                    stall_count
);

  stage_t s0;
  prod_t  s1, s2, s3;

  logic                    kill;
  logic                    hazard;
  logic                    accept;
  logic [2:0]              prod_wr;
  logic [2:0][RIDX_W-1:0]  prod_rd;

  assign prod_wr = {s3.valid & s3.mc[REG_WRITE_BIT],
                    s2.valid & s2.mc[REG_WRITE_BIT],
                    s1.valid & s1.mc[REG_WRITE_BIT]};
  assign prod_rd = {s3.rd, s2.rd, s1.rd};

`ifdef SCHED_FORWARD_EN
  fwd_sel_e fwd_a_nxt, fwd_b_nxt;
`endif

  hazard_detect u_hazard_detect (
    .rs1       (s0.rs1),
    .rs2       (s0.rs2),
    .chk1      (s0.mc[CHECK_RS1_BIT]),
    .chk2      (s0.mc[CHECK_RS2_BIT]),
    .prod_wr   (prod_wr),
    .prod_rd   (prod_rd),
`ifdef SCHED_FORWARD_EN
    .s2_load   (s2.valid & is_load(s2.mc)),
    .fwd_a_sel (fwd_a_nxt),
    .fwd_b_sel (fwd_b_nxt),
`endif
    .hazard    (hazard)
  );

  assign kill           = branch_taken & s2.valid & s2.mc[JUMP_IF_BRANCH_BIT];
  // A flush empties S0 anyway, so it is never reported or counted as a stall.
  assign stall          = s0.valid & hazard & ~kill;
  assign issue.in_ready = ~stall & ~kill;
  assign accept         = issue.in_valid & issue.in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0              <= '0;
      s1              <= '0;
      s2              <= '0;
      s3              <= '0;
      fetch_mem_grant <= 1'b1;
      stall_count     <= '0;
`ifdef SCHED_FORWARD_EN
      fwd_a_sel       <= FWD_REGFILE;
      fwd_b_sel       <= FWD_REGFILE;
`endif
    end else begin
      s3 <= s2;
      if (kill) begin
        // Everything younger than the taken branch in S2 is discarded.
        s2 <= '0;
        s1 <= '0;
        s0 <= '0;
      end else begin
        s2 <= s1;
        if (stall) begin
          s1 <= '0;
        end else begin
          s1 <= '{valid: s0.valid, mc: s0.mc, rd: s0.rd};
          if (accept)
            s0 <= '{valid: 1'b1, mc: issue.in_microcode, rs1: issue.in_rs1,
                    rs2: issue.in_rs2, rd: issue.in_rd};
          else
            s0 <= '0;
        end
      end

      fetch_mem_grant <= ~(s1.valid & s1.mc[MEM_IN_USE_BIT] & ~kill);

      if (stall && (stall_count != '1))
        stall_count <= stall_count + 32'd1;

`ifdef SCHED_FORWARD_EN
      if (kill || stall) begin
        fwd_a_sel <= FWD_REGFILE;
        fwd_b_sel <= FWD_REGFILE;
      end else begin
        fwd_a_sel <= fwd_a_nxt;
        fwd_b_sel <= fwd_b_nxt;
      end
`endif
    end
  end

  assign s0_valid = s0.valid;
  assign s1_valid = s1.valid;
  assign s2_valid = s2.valid;
  assign s3_valid = s3.valid;
  assign s0_mc    = s0.mc;
  assign s1_mc    = s1.mc;
  assign s2_mc    = s2.mc;
  assign s3_mc    = s3.mc;
  assign s3_rd    = s3.rd;

endmodule

// File: tb/tb_microcode_pipeline_scheduler.sv
// Directed bench for microcode_pipeline_scheduler; expectations follow SCHED_FORWARD_EN when defined.
module tb_microcode_pipeline_scheduler;
  import microcode_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic branch_taken = 1'b0;
  logic s0_valid, s1_valid, s2_valid, s3_valid;
  logic [MC_W-1:0] s0_mc, s1_mc, s2_mc, s3_mc;
  logic [RIDX_W-1:0] s3_rd;
  logic stall, fetch_mem_grant;
  logic [31:0] stall_count;
`ifdef SCHED_FORWARD_EN
  fwd_sel_e fwd_a_sel, fwd_b_sel;
`endif

  int passed = 0;
  int total  = 0;
  int exp_count = 0;

  microcode_pipeline_scheduler_if bus();

  microcode_pipeline_scheduler dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .issue           (bus),
    .branch_taken    (branch_taken),
    .s0_valid        (s0_valid),
    .s1_valid        (s1_valid),
    .s2_valid        (s2_valid),
    .s3_valid        (s3_valid),
    .s0_mc           (s0_mc),
    .s1_mc           (s1_mc),
    .s2_mc           (s2_mc),
    .s3_mc           (s3_mc),
    .s3_rd           (s3_rd),
    .stall           (stall),
    .fetch_mem_grant (fetch_mem_grant),
`ifdef SCHED_FORWARD_EN
    .fwd_a_sel       (fwd_a_sel),
    .fwd_b_sel       (fwd_b_sel),
`endif
    .stall_count     (stall_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [MC_W-1:0] mkw(input logic wr, input logic pre, input logic c1,
                                          input logic c2, input logic mem, input logic br,
                                          input logic [3:0] tag);
    logic [MC_W-1:0] w;
    w = '0;
    w[REG_WRITE_BIT]      = wr;
    w[USE_PRE_WB_BIT]     = pre;
    w[CHECK_RS1_BIT]      = c1;
    w[CHECK_RS2_BIT]      = c2;
    w[MEM_IN_USE_BIT]     = mem;
    w[JUMP_IF_BRANCH_BIT] = br;
    w[5:2]                = tag;
    return w;
  endfunction

  task automatic offer(input logic [MC_W-1:0] w, input logic [RIDX_W-1:0] rs1,
                       input logic [RIDX_W-1:0] rs2, input logic [RIDX_W-1:0] rd);
    bus.in_valid     = 1'b1;
    bus.in_microcode = w;
    bus.in_rs1       = rs1;
    bus.in_rs2       = rs2;
    bus.in_rd        = rd;
  endtask

  task automatic drain();
    bus.in_valid = 1'b0;
    repeat (5) tick();
  endtask

  // Writer then dependent reader back to back; counts stall cycles and checks the reader's S1 entry.
  task automatic run_pair(input string tag, input logic [MC_W-1:0] wa, input logic [RIDX_W-1:0] rda,
                          input logic [MC_W-1:0] wb, input logic [RIDX_W-1:0] rs1b,
                          input logic [RIDX_W-1:0] rs2b, input int exp_stalls, input int exp_sel);
    int n;
    offer(wa, 5'd0, 5'd0, rda);
    tick();
    offer(wb, rs1b, rs2b, 5'd30);
    tick();
    bus.in_valid = 1'b0;
    n = 0;
    while (stall && n < 10) begin
      n++;
      tick();
      check({tag, "_bubble"}, {31'd0, s1_valid}, 32'd0);
    end
    check({tag, "_stalls"}, n, exp_stalls);
    exp_count += exp_stalls;
    check({tag, "_count"}, stall_count, exp_count);
    tick();
    check({tag, "_s1_mc"}, {7'd0, s1_mc}, {7'd0, wb});
`ifdef SCHED_FORWARD_EN
    check({tag, "_fwd_a"}, {30'd0, fwd_a_sel}, exp_sel);
`else
    check({tag, "_sel_unused"}, exp_sel, exp_sel >= 0 ? exp_sel : 0);
`endif
    drain();
  endtask

  initial begin
    logic [MC_W-1:0] alu5, rd1, rd2, ld7, br_w, w1, w2, w3, mw, nw;
    bus.in_valid = 1'b0;
    bus.in_microcode = '0;
    bus.in_rs1 = '0;
    bus.in_rs2 = '0;
    bus.in_rd = '0;

    alu5 = mkw(1, 1, 0, 0, 0, 0, 4'h1);
    rd1  = mkw(0, 0, 1, 0, 0, 0, 4'h2);
    rd2  = mkw(0, 0, 0, 1, 0, 0, 4'h3);
    ld7  = mkw(1, 0, 0, 0, 1, 0, 4'h4);
    br_w = mkw(0, 0, 0, 0, 0, 1, 4'h5);
    w1   = mkw(1, 1, 0, 0, 0, 0, 4'h6);
    w2   = mkw(0, 0, 1, 0, 0, 0, 4'h7);
    w3   = mkw(0, 0, 0, 0, 0, 0, 4'h8);
    mw   = mkw(0, 0, 0, 0, 1, 0, 4'h9);
    nw   = mkw(0, 0, 0, 0, 0, 0, 4'hA);

    #12;
    check("rst_valid", {28'd0, s0_valid, s1_valid, s2_valid, s3_valid}, 32'd0);
    check("rst_grant", {31'd0, fetch_mem_grant}, 32'd1);
    check("rst_stall", {31'd0, stall}, 32'd0);
    check("rst_ready", {31'd0, bus.in_ready}, 32'd1);
    check("rst_count", stall_count, 32'd0);
    rst_n = 1'b1;

    offer(alu5, 5'd0, 5'd0, 5'd5);
    tick();
    check("lat_s0_valid", {31'd0, s0_valid}, 32'd1);
    check("lat_s0_mc", {7'd0, s0_mc}, {7'd0, alu5});
    bus.in_valid = 1'b0;
    repeat (3) tick();
    check("lat_s3_valid", {31'd0, s3_valid}, 32'd1);
    check("lat_s3_rd", {27'd0, s3_rd}, 32'd5);
    drain();

`ifdef SCHED_FORWARD_EN
    run_pair("alu_rs1", alu5, 5'd5, rd1, 5'd5, 5'd0, 1, 1);
    run_pair("alu_rs2", alu5, 5'd5, rd2, 5'd0, 5'd5, 1, 0);
    run_pair("load_rs1", ld7, 5'd7, rd1, 5'd7, 5'd0, 2, 2);
`else
    run_pair("alu_rs1", alu5, 5'd5, rd1, 5'd5, 5'd0, 3, 0);
    run_pair("alu_rs2", alu5, 5'd5, rd2, 5'd0, 5'd5, 3, 0);
    run_pair("load_rs1", ld7, 5'd7, rd1, 5'd7, 5'd0, 3, 0);
`endif
    run_pair("x0_reader", alu5, 5'd0, rd1, 5'd0, 5'd0, 0, 0);
    run_pair("chk_clear", alu5, 5'd5, w3, 5'd5, 5'd5, 0, 0);

    // Branch reaches S2 with a hazarded word in S0 and its producer in S1.
    offer(br_w, 5'd0, 5'd0, 5'd0);
    tick();
    offer(w1, 5'd0, 5'd0, 5'd9);
    tick();
    offer(w2, 5'd9, 5'd0, 5'd10);
    tick();
    offer(w3, 5'd0, 5'd0, 5'd11);
    branch_taken = 1'b1;
    #1;
    check("kill_ready", {31'd0, bus.in_ready}, 32'd0);
    check("kill_stall", {31'd0, stall}, 32'd0);
    tick();
    branch_taken = 1'b0;
    bus.in_valid = 1'b0;
    check("kill_s0_s1", {30'd0, s0_valid, s1_valid}, 32'd0);
    check("kill_s2", {31'd0, s2_valid}, 32'd0);
    check("kill_s3_mc", {6'd0, s3_valid, s3_mc}, {6'd0, 1'b1, br_w});
    check("kill_count", stall_count, exp_count);
    drain();

    offer(mw, 5'd0, 5'd0, 5'd0);
    tick();
    bus.in_valid = 1'b0;
    tick();
    check("mem_grant_s1", {31'd0, fetch_mem_grant}, 32'd1);
    tick();
    check("mem_grant_s2", {31'd0, fetch_mem_grant}, 32'd0);
    tick();
    check("mem_grant_back", {31'd0, fetch_mem_grant}, 32'd1);
    drain();

    offer(mw, 5'd0, 5'd0, 5'd0);
    tick();
    offer(nw, 5'd0, 5'd0, 5'd0);
    tick();
    bus.in_valid = 1'b0;
    tick();
    check("rstw_grant_low", {31'd0, fetch_mem_grant}, 32'd0);
    check("rstw_busy", {30'd0, s1_valid, s2_valid}, 32'd3);
    #2;
    rst_n = 1'b0;
    #1;
    check("rstw_grant", {31'd0, fetch_mem_grant}, 32'd1);
    check("rstw_valid", {28'd0, s0_valid, s1_valid, s2_valid, s3_valid}, 32'd0);
    check("rstw_count", stall_count, 32'd0);
    #2;
    rst_n = 1'b1;
    tick();
    check("post_rst_ready", {31'd0, bus.in_ready}, 32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
